// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// Module   : morse_pkg
// Purpose  : Shared definitions for the Morse symbol timer: the 2-bit symbol
//            codes placed in the output queue and the classifier FSM states.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package morse_pkg;

  // Symbol codes carried on sym_code
  localparam logic [1:0] SYM_DOT  = 2'b00;
  localparam logic [1:0] SYM_DASH = 2'b01;
  localparam logic [1:0] SYM_CHAR = 2'b10;
  localparam logic [1:0] SYM_WORD = 2'b11;

  // Classifier states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,  // no gap being timed
    ST_PRESSED   = 2'd1,  // key held, timing a press
    ST_GAP       = 2'd2,  // key released, timing a gap
    ST_WORD_DONE = 2'd3   // word gap already emitted for this release
  } state_t;

endpackage
`default_nettype wire

// File: rtl/morse_sym_fifo.sv
`default_nettype none
// ============================================================================
// Module   : morse_sym_fifo
// Purpose  : Small show-ahead symbol queue. The head entry is presented on
//            out_data whenever out_valid is high; a pop happens when
//            out_valid and pop_ready are both high. A push into a full queue
//            with no same-cycle pop is dropped and latches overflow.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            push, push_data - write request and symbol
//            pop_ready       - consumer accepts the head entry
//            out_valid       - queue non-empty
//            out_data        - head entry (zero when empty)
//            overflow        - sticky drop indicator
// Revision : 1.0 - initial release
// ============================================================================
module morse_sym_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && pop_ready;
  // A full queue still accepts a push when the head leaves in the same cycle
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only observed once written
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/morse_symbol_timer.sv
`default_nettype none
// ============================================================================
// Module   : morse_symbol_timer
// Purpose  : Times a Morse key and classifies each press as dot/dash and each
//            release as no-gap / character gap / word gap, queuing symbols.
//            Path: 2-flop synchroniser -> debouncer -> edge detect ->
//            unit prescaler -> classifier FSM -> morse_sym_fifo.
// Ports    : clk, reset  - clock, synchronous active-high reset
//            button      - raw asynchronous key (1 = pressed)
//            sym_ready   - consumer accepts the head symbol
//            sym_valid   - head symbol valid
//            sym_code    - head symbol (dot/dash/char gap/word gap)
//            busy        - debounced key is held
//            units       - whole units elapsed in current press/gap (sat.)
//            overflow    - sticky: a symbol was dropped on a full queue
// Revision : 1.0 - initial release
// ============================================================================
module morse_symbol_timer
  import morse_pkg::*;
#(
  parameter int CLKS_PER_UNIT  = 50000000,
  parameter int DEBOUNCE_CLKS  = 500000,
  parameter int DASH_UNITS     = 2,
  parameter int CHAR_GAP_UNITS = 2,
  parameter int WORD_GAP_UNITS = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int UNIT_W         = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              button,
  input  logic              sym_ready,
  output logic              sym_valid,
  output logic [1:0]        sym_code,
  output logic              busy,
  output logic [UNIT_W-1:0] units,
  output logic              overflow
);

  localparam int PS_W = (CLKS_PER_UNIT > 1) ? $clog2(CLKS_PER_UNIT) : 1;
  localparam int DB_W = (DEBOUNCE_CLKS > 1) ? $clog2(DEBOUNCE_CLKS) : 1;

  localparam logic [PS_W-1:0]   PS_MAX    = PS_W'(CLKS_PER_UNIT - 1);
  localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CLKS - 1);
  localparam logic [UNIT_W-1:0] DASH_U    = UNIT_W'(DASH_UNITS);
  localparam logic [UNIT_W-1:0] CHAR_U    = UNIT_W'(CHAR_GAP_UNITS);
  localparam logic [UNIT_W-1:0] WORD_U    = UNIT_W'(WORD_GAP_UNITS);

  logic [1:0]      sync_ff;
  logic            db_level;
  logic            db_prev;
  logic [DB_W-1:0] db_cnt;
  logic [PS_W-1:0] prescale;
  logic            db_edge;
  logic            press_edge;
  logic            release_edge;

  state_t          state;
  state_t          state_next;
  logic            push;
  logic [1:0]      push_code;

  // --------------------------------------------------------------------------
  // Synchroniser and debouncer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff  <= 2'b00;
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync_ff <= {sync_ff[0], button};
      db_prev <= db_level;
      if (sync_ff[1] == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        // DEBOUNCE_CLKS consecutive cycles at the new level have been seen
        db_level <= sync_ff[1];
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Edges are taken from the registered debounced level, so the FSM sees
  // each edge for exactly one cycle alongside the not-yet-cleared units.
  assign db_edge      = db_level ^ db_prev;
  assign press_edge   = db_level & ~db_prev;
  assign release_edge = ~db_level & db_prev;

  // --------------------------------------------------------------------------
  // Unit prescaler and saturating unit counter, restarted on every edge
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= '0;
      units    <= '0;
    end else if (db_edge) begin
      prescale <= '0;
      units    <= '0;
    end else if (prescale == PS_MAX) begin
      prescale <= '0;
      if (units != '1) begin
        units <= units + UNIT_W'(1);
      end
    end else begin
      prescale <= prescale + PS_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Classifier FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    push_code  = SYM_DOT;
    case (state)
      ST_IDLE: begin
        if (press_edge) begin
          state_next = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (release_edge) begin
          state_next = ST_GAP;
          push       = 1'b1;
          push_code  = (units < DASH_U) ? SYM_DOT : SYM_DASH;
        end
      end
      ST_GAP: begin
        if (press_edge) begin
          state_next = ST_PRESSED;
          // A press landing on the very cycle the word threshold is reached
          // still reports the word gap rather than losing it.
          if (units >= WORD_U) begin
            push      = 1'b1;
            push_code = SYM_WORD;
          end else if (units >= CHAR_U) begin
            push      = 1'b1;
            push_code = SYM_CHAR;
          end
        end else if (units >= WORD_U) begin
          state_next = ST_WORD_DONE;
          push       = 1'b1;
          push_code  = SYM_WORD;
        end
      end
      ST_WORD_DONE: begin
        if (press_edge) begin
          state_next = ST_PRESSED;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_PRESSED);

  // --------------------------------------------------------------------------
  // Symbol queue
  // --------------------------------------------------------------------------
  morse_sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_code),
    .pop_ready (sym_ready),
    .out_valid (sym_valid),
    .out_data  (sym_code),
    .overflow  (overflow)
  );

endmodule
`default_nettype wire
